l2_set_reader: RTL and testbench
================================

// Module: l2_set_reader
// PURPOSE
//  Front stage of the L2 lookup path. Accepts a set index from the L2 request/forward arbiter and reads
//  every way's tag and per-word state from the tag/state SRAM, plus the replacement victim way.
//  Registers the result into tags_buf/states_buf/evict_way_buf and issues the one-cycle lookup_en
//  pulse (with lookup_mode) that drives the hit/miss/empty-way lookup stage. Holds the buffers stable
//  until the controller releases them, merges controller state updates, and skips the SRAM read on a same-set re-request.
// PARAMETERS
//  WAYS      8   ways per set
//  WORDS     4   words per line
//  TAG_W     16  tag width
//  SET_W     9   set index width
//  STATE_W   3   per-word coherence state width (0 = SPX_I)
//  RAM_LAT   1   SRAM read latency in cycles, >=1
//  (WAY_W = $clog2(WAYS), derived)
// PORTS
//  clk            in   1                     clock
//  rst            in   1                     reset, asynchronous, active-low
//  req_valid      in   1                     set read request
//  req_ready      out  1                     request accepted when valid&ready
//  req_set        in   SET_W                 set index
//  req_mode       in   1                     0 = L2_LOOKUP, 1 = L2_LOOKUP_FWD
//  ram_rd_en      out  1                     SRAM read strobe
//  ram_rd_set     out  SET_W                 SRAM read address
//  ram_tags       in   WAYS*TAG_W            SRAM tag data, way 0 in LSBs
//  ram_states     in   WAYS*WORDS*STATE_W    SRAM state data, way-major, word 0 in LSBs
//  ram_evict_way  in   WAY_W                 SRAM replacement pointer
//  tags_buf       out  WAYS*TAG_W            registered tags
//  states_buf     out  WAYS*WORDS*STATE_W    registered states
//  evict_way_buf  out  WAY_W                 registered victim way
//  buf_set        out  SET_W                 set held in buffers
//  bufs_valid     out  1                     buffers hold a complete, stable set
//  lookup_en      out  1                     1-cycle pulse to the lookup stage
//  lookup_mode    out  1                     registered req_mode
//  release        in   1                     controller is done with the buffers
//  upd_en         in   1                     write state into buffers (legal only while bufs_valid)
//  upd_way        in   WAY_W                 way to update
//  upd_word_mask  in   WORDS                 words to update
//  upd_state      in   STATE_W               new state
//  inv_reuse      in   1                     external SRAM write; buffered copy is stale
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; reuse flag cleared.
//  FSM states and transitions:
//   IDLE: req_ready=1. On accept, latch req_set and req_mode. If reuse&&req_set==buf_set -> LOOKUP;
//    otherwise -> READ.
//   READ: ram_rd_en=1, ram_rd_set=latched set, for 1 cycle. Load counter=RAM_LAT-1 -> WAIT.
//   WAIT: decrement counter. At 0, capture ram_* into buffers, set buf_set -> LOOKUP.
//   LOOKUP: lookup_en=1 for exactly 1 cycle; bufs_valid=1 -> HOLD.
//   HOLD: bufs_valid=1. On release -> IDLE.
//   A request on the release cycle is NOT accepted (req_ready=0 in HOLD).
//  Latency: req accepted at cycle T; lookup_en at T+2+RAM_LAT. Reuse hit gives lookup_en at T+1.
//  ram_rd_en/ram_rd_set are combinational from state, so the SRAM sees the address in the READ cycle.
//  bufs_valid drops on the cycle after release; buffer contents are retained for reuse.
//  Update: upd_en in LOOKUP or HOLD sets states_buf[upd_way][w]=upd_state for each w with mask bit
//   set, taking effect next cycle. upd_en in any other state is ignored; the assertion checker flags it.
//  Reuse: flag is set on SRAM capture. inv_reuse clears it in any state. If inv_reuse coincides with
//   the WAIT capture, clear wins, but the captured data is still used for the current lookup.
//  release outside HOLD is ignored. Reset mid-operation returns to IDLE immediately and drops lookup_en.
// TESTING
//  1 Cold read, RAM_LAT=1, set 0x05, mode 0 -> ram_rd_en at T+1; lookup_en at T+3; buffers==RAM data; buf_set=0x05.
//  2 RAM_LAT=3 -> lookup_en exactly at T+5; req_ready=0 from T+1 until the cycle after release.
//  3 Re-request set 0x05 after release, no inv -> no ram_rd_en; lookup_en at T+1 with identical buffers.
//  4 upd_en way 2, mask 4'b0101, state 3 in HOLD -> words 0 and 2 of way 2 read 3 next cycle; others unchanged.
//  5 inv_reuse pulse, then re-request 0x05 -> full SRAM read is performed (ram_rd_en=1).
//  6 rst low during WAIT -> outputs 0; state IDLE; next request takes the cold-read path.

Source files
------------

// File: rtl/l2_set_reader.sv
// l2_set_reader: front stage of the L2 lookup path.
// Reads every way's tag, per-word state and the replacement victim for one set,
// registers them into stable buffers and pulses lookup_en once per request.
// Buffers stay valid until the controller releases them. A re-request of the
// still-buffered set skips the SRAM read unless an external SRAM write has
// invalidated the buffered copy.
module l2_set_reader #(
   parameter  int WAYS    = 8,
   parameter  int WORDS   = 4,
   parameter  int TAG_W   = 16,
   parameter  int SET_W   = 9,
   parameter  int STATE_W = 3,
   parameter  int RAM_LAT = 1,
   localparam int WAY_W   = $clog2(WAYS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [SET_W-1:0]                 req_set,
   input  logic                             req_mode,
   output logic                             ram_rd_en,
   output logic [SET_W-1:0]                 ram_rd_set,
   input  logic [WAYS*TAG_W-1:0]            ram_tags,
   input  logic [WAYS*WORDS*STATE_W-1:0]    ram_states,
   input  logic [WAY_W-1:0]                 ram_evict_way,
   output logic [WAYS*TAG_W-1:0]            tags_buf,
   output logic [WAYS*WORDS*STATE_W-1:0]    states_buf,
   output logic [WAY_W-1:0]                 evict_way_buf,
   output logic [SET_W-1:0]                 buf_set,
   output logic                             bufs_valid,
   output logic                             lookup_en,
   output logic                             lookup_mode,
   input  logic                             release_bufs,
   input  logic                             upd_en,
   input  logic [WAY_W-1:0]                 upd_way,
   input  logic [WORDS-1:0]                 upd_word_mask,
   input  logic [STATE_W-1:0]               upd_state,
   input  logic                             inv_reuse
);

   localparam int TAGS_W   = WAYS * TAG_W;
   localparam int STATES_W = WAYS * WORDS * STATE_W;
   localparam int CNT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      WAIT   = 3'd2,
      LOOKUP = 3'd3,
      HOLD   = 3'd4
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [SET_W-1:0]   set_q;
   logic               mode_q;
   logic               reuse_q;
   logic               accept;
   logic               reuse_hit;
   logic               capture;
   logic               upd_window;

   // Overwrite the selected words of one way with a new coherence state.
   function automatic logic [STATES_W-1:0] merge_state(
      input logic [STATES_W-1:0] cur,
      input logic [WAY_W-1:0]    way,
      input logic [WORDS-1:0]    mask,
      input logic [STATE_W-1:0]  st
   );
      logic [STATES_W-1:0] res;
      res = cur;
      for (int w = 0; w < WORDS; w++) begin
         if (mask[w]) begin
            res[(int'(way) * WORDS + w) * STATE_W +: STATE_W] = st;
         end
      end
      return res;
   endfunction

   assign accept     = req_valid & req_ready;
   assign reuse_hit  = reuse_q && (req_set == buf_set);
   assign capture    = (state_q == WAIT) && (cnt_q == '0);
   assign upd_window = (state_q == LOOKUP) || (state_q == HOLD);

   // Control outputs decode straight from the state so the SRAM sees the
   // address during the READ cycle and reset silences everything at once.
   assign req_ready   = rst && (state_q == IDLE);
   assign ram_rd_en   = (state_q == READ);
   assign ram_rd_set  = (state_q == READ) ? set_q : '0;
   assign lookup_en   = (state_q == LOOKUP);
   assign bufs_valid  = upd_window;
   assign lookup_mode = mode_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; HOLD deliberately ignores new requests on the release cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = reuse_hit ? LOOKUP : READ;
            end
         end
         READ: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (release_bufs) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // SRAM latency counter: loaded in READ, counts down through WAIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (state_q == READ) begin
         cnt_q <= CNT_W'(RAM_LAT - 1);
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Latch the accepted request's set and mode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         set_q  <= '0;
         mode_q <= 1'b0;
      end else if (accept) begin
         set_q  <= req_set;
         mode_q <= req_mode;
      end
   end

   // Reuse flag: armed by a fresh SRAM capture, cleared by any external SRAM
   // write; a clear coinciding with the capture wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reuse_q <= 1'b0;
      end else if (inv_reuse) begin
         reuse_q <= 1'b0;
      end else if (capture) begin
         reuse_q <= 1'b1;
      end
   end

   // Result buffers: loaded from the SRAM on capture, merged with controller
   // state updates while valid, retained afterwards for a possible reuse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tags_buf      <= '0;
         states_buf    <= '0;
         evict_way_buf <= '0;
         buf_set       <= '0;
      end else if (capture) begin
         tags_buf      <= ram_tags[TAGS_W-1:0];
         states_buf    <= ram_states[STATES_W-1:0];
         evict_way_buf <= ram_evict_way;
         buf_set       <= set_q;
      end else if (upd_en && upd_window) begin
         states_buf    <= merge_state(states_buf, upd_way, upd_word_mask, upd_state);
      end
   end

   // A state update is only meaningful while the buffers are valid.
   upd_only_when_valid : assert property (@(posedge clk) disable iff (!rst)
      upd_en |-> ((state_q == LOOKUP) || (state_q == HOLD)));

endmodule

// File: tb/tb_l2_set_reader.sv
// Testbench for l2_set_reader: an SRAM model with configurable read latency
// feeds the DUT; a transaction-level reference (buffer copy, reuse flag,
// expected latency) predicts every observable result.
module tb_l2_set_reader;

   localparam int WAYS     = 8;
   localparam int WORDS    = 4;
   localparam int TAG_W    = 16;
   localparam int SET_W    = 9;
   localparam int STATE_W  = 3;
   localparam int RAM_LAT  = 3;
   localparam int WAY_W    = 3;
   localparam int TAGS_W   = WAYS * TAG_W;
   localparam int STATES_W = WAYS * WORDS * STATE_W;

   logic                clk = 1'b0;
   logic                rst;
   logic                req_valid;
   logic                req_ready;
   logic [SET_W-1:0]    req_set;
   logic                req_mode;
   logic                ram_rd_en;
   logic [SET_W-1:0]    ram_rd_set;
   logic [TAGS_W-1:0]   ram_tags;
   logic [STATES_W-1:0] ram_states;
   logic [WAY_W-1:0]    ram_evict_way;
   logic [TAGS_W-1:0]   tags_buf;
   logic [STATES_W-1:0] states_buf;
   logic [WAY_W-1:0]    evict_way_buf;
   logic [SET_W-1:0]    buf_set;
   logic                bufs_valid;
   logic                lookup_en;
   logic                lookup_mode;
   logic                release_bufs;
   logic                upd_en;
   logic [WAY_W-1:0]    upd_way;
   logic [WORDS-1:0]    upd_word_mask;
   logic [STATE_W-1:0]  upd_state;
   logic                inv_reuse;

   int n_cmp = 0;
   int n_bad = 0;

   // SRAM contents
   logic [TAGS_W-1:0]   mem_tags   [512];
   logic [STATES_W-1:0] mem_states [512];
   logic [WAY_W-1:0]    mem_ev     [512];

   // read pipeline of the SRAM model
   logic                p_vld [RAM_LAT];
   logic [SET_W-1:0]    p_set [RAM_LAT];

   // reference model of the buffered copy
   logic [TAGS_W-1:0]   m_tags;
   logic [STATES_W-1:0] m_states;
   logic [WAY_W-1:0]    m_ev;
   logic [SET_W-1:0]    m_set;
   bit                  m_reuse;

   l2_set_reader #(
      .WAYS(WAYS), .WORDS(WORDS), .TAG_W(TAG_W), .SET_W(SET_W),
      .STATE_W(STATE_W), .RAM_LAT(RAM_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_mode(req_mode),
      .ram_rd_en(ram_rd_en), .ram_rd_set(ram_rd_set), .ram_tags(ram_tags),
      .ram_states(ram_states), .ram_evict_way(ram_evict_way),
      .tags_buf(tags_buf), .states_buf(states_buf), .evict_way_buf(evict_way_buf),
      .buf_set(buf_set), .bufs_valid(bufs_valid), .lookup_en(lookup_en),
      .lookup_mode(lookup_mode), .release_bufs(release_bufs),
      .upd_en(upd_en), .upd_way(upd_way), .upd_word_mask(upd_word_mask),
      .upd_state(upd_state), .inv_reuse(inv_reuse)
   );

   always #5 clk = ~clk;

   // SRAM model: data appears RAM_LAT cycles after the read strobe; junk otherwise.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < RAM_LAT; i++) begin
            p_vld[i] <= 1'b0;
            p_set[i] <= '0;
         end
      end else begin
         p_vld[0] <= ram_rd_en;
         p_set[0] <= ram_rd_set;
         for (int i = 1; i < RAM_LAT; i++) begin
            p_vld[i] <= p_vld[i-1];
            p_set[i] <= p_set[i-1];
         end
      end
   end

   assign ram_tags      = p_vld[RAM_LAT-1] ? mem_tags[p_set[RAM_LAT-1]]   : {WAYS{16'hDEAD}};
   assign ram_states    = p_vld[RAM_LAT-1] ? mem_states[p_set[RAM_LAT-1]] : {STATES_W{1'b1}};
   assign ram_evict_way = p_vld[RAM_LAT-1] ? mem_ev[p_set[RAM_LAT-1]]     : {WAY_W{1'b1}};

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [SET_W-1:0] pick_set();
      case ($urandom_range(0, 2))
         0:       return 9'h005;
         1:       return 9'h1FF;
         default: return 9'h0A0;
      endcase
   endfunction

   task automatic rewrite_mem(input logic [SET_W-1:0] s);
      mem_tags[s]   = {$urandom, $urandom, $urandom, $urandom};
      mem_states[s] = {$urandom, $urandom, $urandom};
      mem_ev[s]     = WAY_W'($urandom);
   endtask

   // Issue one request from IDLE; returns at the lookup cycle (mid-cycle).
   task automatic request(input logic [SET_W-1:0] s, input logic m, input bit inv_cap, input bit noise);
      bit hit;
      bit seen;
      int exp_lat;
      int k;
      int nrd;
      hit     = m_reuse && (s == m_set);
      exp_lat = hit ? 1 : 2 + RAM_LAT;
      chk("idle_ready", req_ready, 1);
      req_valid = 1'b1;
      req_set   = s;
      req_mode  = m;
      @(negedge clk);
      req_valid = 1'b0;
      req_set   = SET_W'($urandom);
      k    = 1;
      nrd  = 0;
      seen = 0;
      while (k <= 12 && !seen) begin
         inv_reuse = inv_cap && (k == 1 + RAM_LAT);
         if (ram_rd_en) begin
            nrd++;
            chk("rd_set", ram_rd_set, s);
         end
         if (lookup_en) begin
            seen = 1;
         end else begin
            chk("busy_ready", req_ready, 0);
            chk("busy_bvalid", bufs_valid, 0);
            release_bufs = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            k++;
         end
      end
      inv_reuse    = 1'b0;
      release_bufs = 1'b0;
      chk("lookup_seen", seen, 1);
      chk("latency", k, exp_lat);
      chk("rd_count", nrd, hit ? 0 : 1);
      if (!hit) begin
         m_tags   = mem_tags[s];
         m_states = mem_states[s];
         m_ev     = mem_ev[s];
         m_set    = s;
         m_reuse  = !inv_cap;
      end
      chk("tags", tags_buf, m_tags);
      chk("states", states_buf, m_states);
      chk("evict", evict_way_buf, m_ev);
      chk("buf_set", buf_set, m_set);
      chk("mode", lookup_mode, m);
      chk("lk_bvalid", bufs_valid, 1);
   endtask

   // Stay n cycles with buffers valid, optionally mixing in updates and invalidations.
   task automatic hold(input int n, input bit noise);
      for (int i = 0; i < n; i++) begin
         if (noise && $urandom_range(0, 1) == 1) begin
            upd_en        = 1'b1;
            upd_way       = WAY_W'($urandom);
            upd_word_mask = WORDS'($urandom);
            upd_state     = STATE_W'($urandom);
            for (int w = 0; w < WORDS; w++) begin
               if (upd_word_mask[w]) m_states[(int'(upd_way) * WORDS + w) * STATE_W +: STATE_W] = upd_state;
            end
         end
         if (noise && $urandom_range(0, 3) == 0) begin
            inv_reuse = 1'b1;
            m_reuse   = 0;
            rewrite_mem(pick_set());
         end
         @(negedge clk);
         upd_en    = 1'b0;
         inv_reuse = 1'b0;
         chk("hold_lookup", lookup_en, 0);
         chk("hold_bvalid", bufs_valid, 1);
         chk("hold_ready", req_ready, 0);
         chk("hold_states", states_buf, m_states);
         chk("hold_tags", tags_buf, m_tags);
      end
   endtask

   // Release in HOLD; a request offered on the release cycle must not be taken.
   task automatic do_release(input bit offer_req);
      release_bufs = 1'b1;
      if (offer_req) begin
         req_valid = 1'b1;
         req_set   = SET_W'($urandom);
      end
      @(negedge clk);
      release_bufs = 1'b0;
      chk("rel_bvalid", bufs_valid, 0);
      chk("rel_ready", req_ready, 1);
      chk("rel_lookup", lookup_en, 0);
      chk("rel_rd", ram_rd_en, 0);
      chk("rel_states", states_buf, m_states);
      chk("rel_set", buf_set, m_set);
      req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_set = '0; req_mode = 1'b0;
      release_bufs = 1'b0; upd_en = 1'b0; upd_way = '0; upd_word_mask = '0;
      upd_state = '0; inv_reuse = 1'b0;
      for (int i = 0; i < 512; i++) rewrite_mem(SET_W'(i));
      m_tags = '0; m_states = '0; m_ev = '0; m_set = '0; m_reuse = 0;

      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_lookup", lookup_en, 0);
      chk("rst_bvalid", bufs_valid, 0);
      chk("rst_rd", ram_rd_en, 0);
      chk("rst_tags", tags_buf, 0);
      chk("rst_set", buf_set, 0);
      rst = 1'b1;
      @(negedge clk);

      // cold read, then a reuse hit with a different mode
      request(9'h005, 1'b0, 0, 0);
      hold(2, 0);
      do_release(1);
      request(9'h005, 1'b1, 0, 0);
      hold(1, 0);

      // directed update: way 2, words 0 and 2 become state 3
      upd_en = 1'b1; upd_way = 3'd2; upd_word_mask = 4'b0101; upd_state = 3'd3;
      m_states[(2 * WORDS + 0) * STATE_W +: STATE_W] = 3'd3;
      m_states[(2 * WORDS + 2) * STATE_W +: STATE_W] = 3'd3;
      @(negedge clk);
      upd_en = 1'b0;
      chk("upd_w0", states_buf[(2 * WORDS + 0) * STATE_W +: STATE_W], 3);
      chk("upd_w2", states_buf[(2 * WORDS + 2) * STATE_W +: STATE_W], 3);
      chk("upd_all", states_buf, m_states);
      do_release(0);

      // invalidation while idle forces a full read with fresh data
      inv_reuse = 1'b1;
      rewrite_mem(9'h005);
      m_reuse = 0;
      @(negedge clk);
      inv_reuse = 1'b0;
      request(9'h005, 1'b0, 0, 0);
      hold(1, 0);
      do_release(0);

      // invalidation coinciding with the capture: data used, reuse not armed
      request(9'h1FF, 1'b0, 1, 0);
      hold(1, 0);
      do_release(0);
      request(9'h1FF, 1'b1, 0, 0);
      hold(1, 0);
      do_release(0);

      // reset in the middle of WAIT
      req_valid = 1'b1; req_set = 9'h005; req_mode = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_lookup", lookup_en, 0);
      chk("mid_rst_bvalid", bufs_valid, 0);
      chk("mid_rst_rd", ram_rd_en, 0);
      chk("mid_rst_tags", tags_buf, 0);
      chk("mid_rst_states", states_buf, 0);
      chk("mid_rst_set", buf_set, 0);
      chk("mid_rst_mode", lookup_mode, 0);
      m_tags = '0; m_states = '0; m_ev = '0; m_set = '0; m_reuse = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      request(9'h005, 1'b0, 0, 0);
      hold(1, 0);
      do_release(0);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         request(pick_set(), 1'($urandom), 0, 1);
         hold($urandom_range(1, 4), 1);
         do_release(1'($urandom));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
